div_seq_param: RTL

// - Parametrised iterative integer divider: restoring algorithm, one quotient bit per clock.
// - Handles signed and unsigned operands, selected per operation by signed_op.
// - Adds divide-by-zero detection, a start/busy/done handshake, and results held stable until the next operation.
// - Sits beside the ALU in the multicycle datapath; the control FSM issues start, waits for done, then writes back.

---
 rtl/div_seq_param.sv | 106 ++++++++++
 1 files changed

// File: rtl/div_seq_param.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Results and the divide-by-zero flag are held until the next operation completes.
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, d_q, r_q;
  logic             sign_q, sign_r, dz_q;

  logic             accept, last;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] r_nx, a_nx, q_res, r_res;

  assign accept  = start && (state != CALC);
  assign dvd_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_abs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  // The working remainder gets one extra bit so the compare against D cannot overflow.
  assign r_sh = {r_q, a_q[WIDTH-1]};
  assign ge   = r_sh >= {1'b0, d_q};
  assign r_nx = ge ? (r_sh[WIDTH-1:0] - d_q) : r_sh[WIDTH-1:0];
  assign a_nx = {a_q[WIDTH-2:0], ge};

  assign last = (state == CALC) && (dz_q || (cnt == CW'(WIDTH-1)));

  // Divide by zero never shifts, so a_q still holds |dividend| and re-signing restores it.
  always_comb begin
    q_res = sign_q ? -a_nx : a_nx;
    r_res = sign_r ? -r_nx : r_nx;
    if (dz_q) begin
      q_res = '1;
      r_res = sign_r ? -a_q : a_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = DONE;
      DONE:    state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz_q        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_q    <= dvd_abs;
      d_q    <= dvs_abs;
      r_q    <= '0;
      sign_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      sign_r <= signed_op && dividend[WIDTH-1];
      dz_q   <= (divisor == '0);
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      a_q <= a_nx;
      r_q <= r_nx;
      if (last) begin
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= dz_q;
      end
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
